// File: rtl/alu_div.sv
// Iterative restoring radix-2 divider for MIPS DIV/DIVU.
// Lo = quotient, Hi = remainder; fixed latency, pulse handshake.
module alu_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validIn,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             validOut,
  output logic             divByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             vout_q, vout_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   rs, diff;

  assign mag_a = (isSigned & SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign mag_b = (isSigned & SrcB[WIDTH-1]) ? -SrcB : SrcB;

  // Shifted remainder keeps its carry-out bit, so the compare never wraps.
  assign rs   = {r_q, q_q[WIDTH-1]};
  assign diff = rs - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    vout_d  = 1'b0;
    dbz_d   = dbz_q;
    if (validIn) begin
      state_d = CALC;
      q_d     = mag_a;
      b_d     = mag_b;
      r_d     = '0;
      cnt_d   = '0;
      sa_d    = isSigned & SrcA[WIDTH-1];
      sb_d    = isSigned & SrcB[WIDTH-1];
      zero_d  = (SrcB == '0);
    end else begin
      unique case (state_q)
        IDLE: ;
        CALC: begin
          r_d   = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], ~diff[WIDTH]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1))
            state_d = FIX;
        end
        FIX: begin
          lo_d    = (sa_q ^ sb_q) ? -q_q : q_q;
          hi_d    = sa_q ? -r_q : r_q;
          vout_d  = 1'b1;
          dbz_d   = zero_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      vout_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      vout_q  <= vout_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign validOut  = vout_q;
  assign divByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div against an
// arithmetic reference model.
module tb_alu_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        validIn;
  logic        isSigned;
  logic [31:0] SrcA, SrcB;
  logic        busy, validOut, divByZero;
  logic [31:0] Hi, Lo;

  int tests = 0;
  int fails = 0;

  alu_div dut (
    .clk      (clk),
    .reset    (reset),
    .validIn  (validIn),
    .isSigned (isSigned),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .busy     (busy),
    .validOut (validOut),
    .divByZero(divByZero),
    .Hi       (Hi),
    .Lo       (Lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  bit          s,
    output logic [31:0] lo,
    output logic [31:0] hi,
    output logic        dz
  );
    longint sa, sb, qq, rr;
    logic [31:0] mag, ones;
    dz = (b == 32'h0);
    if (dz) begin
      ones = 32'hFFFF_FFFF;
      mag  = (s && a[31]) ? (32'h0 - a) : a;
      lo   = (s && a[31]) ? (32'h0 - ones) : ones;
      hi   = (s && a[31]) ? (32'h0 - mag) : mag;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      lo = qq[31:0];
      hi = rr[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  task automatic start(
    input logic [31:0] a,
    input logic [31:0] b,
    input bit          s
  );
    SrcA     = a;
    SrcB     = b;
    isSigned = s;
    validIn  = 1'b1;
    tick();
    validIn  = 1'b0;
  endtask

  // Observe 40 cycles after a sampled start edge.
  task automatic observe(
    output int nv,
    output int lat,
    output int nbusy,
    output logic [31:0] lo,
    output logic [31:0] hi,
    output logic dz
  );
    nv = 0; lat = -1; nbusy = 0;
    lo = 'x; hi = 'x; dz = 1'bx;
    for (int c = 0; c < 40; c++) begin
      if (validOut) begin
        nv++;
        if (nv == 1) begin
          lat = c; lo = Lo; hi = Hi; dz = divByZero;
        end
      end
      if (busy) nbusy++;
      tick();
    end
  endtask

  task automatic run_check(
    input string nm,
    input logic [31:0] a,
    input logic [31:0] b,
    input bit s
  );
    int nv, lat, nb;
    logic [31:0] lo, hi, elo, ehi;
    logic dz, edz;
    model(a, b, s, elo, ehi, edz);
    start(a, b, s);
    observe(nv, lat, nb, lo, hi, dz);
    tests++;
    if (nv !== 1 || lat !== 33 || lo !== elo || hi !== ehi || dz !== edz) begin
      fails++;
      $display("FAIL %s: nv=%0d lat=%0d lo=%h hi=%h dz=%b, want nv=1 lat=33 lo=%h hi=%h dz=%b",
               nm, nv, lat, lo, hi, dz, elo, ehi, edz);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; validIn = 1'b0; isSigned = 1'b0;
    SrcA = '0; SrcB = '0;
    #12;
    tests++;
    if (busy !== 0 || validOut !== 0 || divByZero !== 0 || Hi !== 0 || Lo !== 0) begin
      fails++;
      $display("FAIL reset: busy=%b vo=%b dz=%b hi=%h lo=%h, want all 0",
               busy, validOut, divByZero, Hi, Lo);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    int nv, lat, nb;
    logic [31:0] lo, hi;
    logic dz;
    start(32'd100, 32'd7, 1'b0);
    observe(nv, lat, nb, lo, hi, dz);
    tests++;
    if (nv !== 1 || lat !== 33) begin
      fails++;
      $display("FAIL latency: nv=%0d lat=%0d, want 1/33", nv, lat);
    end
    tests++;
    if (nb !== 33) begin
      fails++;
      $display("FAIL busy_cycles: got %0d, want 33", nb);
    end
    tests++;
    if (lo !== 32'd14 || hi !== 32'd2 || dz !== 1'b0) begin
      fails++;
      $display("FAIL divu_100_7: lo=%0d hi=%0d dz=%b, want 14 2 0", lo, hi, dz);
    end
    tests++;
    if (Lo !== 32'd14 || Hi !== 32'd2) begin
      fails++;
      $display("FAIL hold_idle: lo=%0d hi=%0d, want 14 2", Lo, Hi);
    end
  endtask

  task automatic test_corners();
    run_check("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_check("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    run_check("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_check("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_check("divu_5_0", 32'd5, 32'd0, 1'b0);
    run_check("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1);
    run_check("divu_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_check("divu_max_big", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
  endtask

  task automatic test_restart();
    int nv, lat, nb;
    logic [31:0] lo, hi;
    logic dz;
    start(32'd100, 32'd7, 1'b0);
    repeat (10) tick();
    start(32'd9, 32'd3, 1'b0);
    observe(nv, lat, nb, lo, hi, dz);
    tests++;
    if (nv !== 1 || lat !== 33 || lo !== 32'd3 || hi !== 32'd0) begin
      fails++;
      $display("FAIL restart: nv=%0d lat=%0d lo=%h hi=%h, want 1 33 3 0",
               nv, lat, lo, hi);
    end
  endtask

  task automatic test_fix_abort();
    int nv, lat, nb;
    logic [31:0] lo, hi;
    logic dz;
    logic [31:0] plo, phi;
    plo = Lo; phi = Hi;
    start(32'd1000, 32'd9, 1'b0);
    repeat (32) tick();
    start(32'd50, 32'd8, 1'b0);
    tests++;
    if (validOut !== 1'b0 || Lo !== plo || Hi !== phi) begin
      fails++;
      $display("FAIL fix_abort_hold: vo=%b lo=%h hi=%h, want 0 %h %h",
               validOut, Lo, Hi, plo, phi);
    end
    observe(nv, lat, nb, lo, hi, dz);
    tests++;
    if (nv !== 1 || lat !== 33 || lo !== 32'd6 || hi !== 32'd2) begin
      fails++;
      $display("FAIL fix_abort: nv=%0d lat=%0d lo=%h hi=%h, want 1 33 6 2",
               nv, lat, lo, hi);
    end
  endtask

  task automatic test_reset_mid();
    int nv, lat, nb;
    logic [31:0] lo, hi;
    logic dz;
    start(32'd12345, 32'd17, 1'b0);
    repeat (20) tick();
    reset = 1'b1;
    #2;
    tests++;
    if (busy !== 0 || validOut !== 0 || Hi !== 0 || Lo !== 0 || divByZero !== 0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b vo=%b hi=%h lo=%h dz=%b, want 0",
               busy, validOut, Hi, Lo, divByZero);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    observe(nv, lat, nb, lo, hi, dz);
    tests++;
    if (nv !== 0 || nb !== 0) begin
      fails++;
      $display("FAIL reset_quiet: nv=%0d busy=%0d, want 0 0", nv, nb);
    end
    run_check("after_reset", 32'd12345, 32'd17, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    unique case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a, b;
      bit s;
      a = pick();
      b = pick();
      s = bit'($urandom_range(0, 1));
      run_check("random", a, b, s);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_corners();
    test_restart();
    test_fix_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
